// File: rtl/dbus_bridge.sv
// Data-bus bridge between the core load/store port, on-chip RAM and the GEMM MMIO window.
// Optional macro BUS_TIMEOUT_EN adds an accelerator ack timeout that raises bus_err.
module dbus_bridge #(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] ACC_BASE  = 32'h8000_0000,
    parameter logic [31:0] ACC_MASK  = 32'hFFFF_F000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cs,
    input  logic                         mem_rd_wr,
    input  logic [3:0]                   mask,
    input  logic [31:0]                  mem_addr,
    input  logic [31:0]                  mem_write_data,
    output logic [31:0]                  mem_read_data,
    output logic                         mem_valid,
    output logic                         ram_en,
    output logic [3:0]                   ram_we,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    output logic                         acc_req,
    output logic                         acc_we,
    output logic [11:0]                  acc_addr,
    output logic [31:0]                  acc_wdata,
    output logic [3:0]                   acc_mask,
    input  logic                         acc_ack,
    input  logic [31:0]                  acc_rdata,
    output logic                         bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_LIMIT = 33'(RAM_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_RD   = 2'd1,
        ACC_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] rdata_q;
    logic        is_acc;
    logic        is_ram;
    logic        timeout_hit;

    // Accelerator window wins over the RAM range when both would match.
    assign is_acc = (mem_addr & ACC_MASK) == ACC_BASE;
    assign is_ram = !is_acc && ({1'b0, mem_addr} < RAM_LIMIT);

    assign ram_addr  = mem_addr[2 +: AW];
    assign ram_wdata = mem_write_data;

`ifdef BUS_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        bus_err_q;

    assign timeout_hit = (state == ACC_WAIT) && (tmo_cnt == 32'(TIMEOUT - 1));
    assign bus_err     = bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt   <= (state == ACC_WAIT && state_next == ACC_WAIT) ? tmo_cnt + 32'd1 : '0;
            // An ack on the timeout cycle takes precedence, so no error then.
            bus_err_q <= timeout_hit && !acc_ack;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        mem_valid     = 1'b1;
        mem_read_data = 32'h0;
        ram_en        = 1'b0;
        ram_we        = 4'h0;
        case (state)
            IDLE: begin
                if (cs) begin
                    if (is_acc) begin
                        mem_valid  = 1'b0;
                        state_next = ACC_WAIT;
                    end else if (is_ram) begin
                        ram_en = 1'b1;
                        if (mem_rd_wr) begin
                            mem_valid  = 1'b0;
                            state_next = RAM_RD;
                        end else begin
                            ram_we = mask;
                        end
                    end
                end
            end
            RAM_RD: begin
                mem_read_data = ram_rdata;
                state_next    = IDLE;
            end
            ACC_WAIT: begin
                mem_valid = 1'b0;
                if (acc_ack || timeout_hit) state_next = RESP;
            end
            RESP: begin
                mem_read_data = rdata_q;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc_req   <= 1'b0;
            acc_we    <= 1'b0;
            acc_addr  <= 12'h0;
            acc_wdata <= 32'h0;
            acc_mask  <= 4'h0;
            rdata_q   <= 32'h0;
        end else begin
            state <= state_next;
            if (state == IDLE && cs && is_acc) begin
                acc_req   <= 1'b1;
                acc_we    <= ~mem_rd_wr;
                acc_addr  <= mem_addr[11:0];
                acc_wdata <= mem_write_data;
                acc_mask  <= mask;
            end else if (state == ACC_WAIT && acc_ack) begin
                acc_req <= 1'b0;
                rdata_q <= acc_we ? 32'h0 : acc_rdata;
            end else if (timeout_hit) begin
                acc_req <= 1'b0;
                rdata_q <= 32'hDEAD_BEEF;
            end
        end
    end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: RAM, unmapped, accelerator, reset-abort and timeout paths.
module tb_dbus_bridge;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        mem_rd_wr;
    logic [3:0]  mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_valid;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        acc_req;
    logic        acc_we;
    logic [11:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_mask;
    logic        acc_ack;
    logic [31:0] acc_rdata;
    logic        bus_err;

    int checks = 0;
    int passes = 0;

    logic [31:0] ram_mem [0:4095];

    dbus_bridge #(
        .RAM_WORDS(4096),
        .ACC_BASE (32'h8000_0000),
        .ACC_MASK (32'hFFFF_F000),
        .TIMEOUT  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .mem_rd_wr     (mem_rd_wr),
        .mask          (mask),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data),
        .mem_valid     (mem_valid),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .acc_req       (acc_req),
        .acc_we        (acc_we),
        .acc_addr      (acc_addr),
        .acc_wdata     (acc_wdata),
        .acc_mask      (acc_mask),
        .acc_ack       (acc_ack),
        .acc_rdata     (acc_rdata),
        .bus_err       (bus_err)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM model: byte writes, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_we == 4'h0) ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        cs = c; mem_rd_wr = rd; mem_addr = a; mem_write_data = d; mask = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        acc_ack = 1'b0; acc_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        checks++; if (mem_valid !== 1'b1) $display("FAIL reset_valid got %0h exp 1", mem_valid); else passes++;
        checks++; if (acc_req !== 1'b0) $display("FAIL reset_acc_req got %0h exp 0", acc_req); else passes++;
        checks++; if (mem_read_data !== 32'h0) $display("FAIL reset_rdata got %h exp 0", mem_read_data); else passes++;
        checks++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %0h exp 0", bus_err); else passes++;
        checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en got %0h exp 0", ram_en); else passes++;
    endtask

    task automatic test_ram_write_read();
        tick();
        drive(1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 4'hF);
        sample();
        checks++; if (mem_valid !== 1'b1) $display("FAIL wr_valid got %0h exp 1", mem_valid); else passes++;
        checks++; if (ram_en !== 1'b1) $display("FAIL wr_ram_en got %0h exp 1", ram_en); else passes++;
        checks++; if (ram_we !== 4'hF) $display("FAIL wr_ram_we got %h exp f", ram_we); else passes++;
        checks++; if (ram_addr !== 12'd4) $display("FAIL wr_ram_addr got %h exp 004", ram_addr); else passes++;
        checks++; if (ram_wdata !== 32'hCAFE_F00D) $display("FAIL wr_ram_wdata got %h exp cafef00d", ram_wdata); else passes++;
        tick();
        drive(1'b1, 1'b1, 32'h10, 32'h0, 4'h0);
        sample();
        checks++; if (mem_valid !== 1'b0) $display("FAIL rd_wait_valid got %0h exp 0", mem_valid); else passes++;
        checks++; if (ram_en !== 1'b1 || ram_we !== 4'h0) $display("FAIL rd_ram_ctl got en=%0h we=%h exp en=1 we=0", ram_en, ram_we); else passes++;
        tick();
        sample();
        checks++; if (mem_valid !== 1'b1) $display("FAIL rd_done_valid got %0h exp 1", mem_valid); else passes++;
        checks++; if (mem_read_data !== 32'hCAFE_F00D) $display("FAIL rd_data got %h exp cafef00d", mem_read_data); else passes++;
        checks++; if (ram_en !== 1'b0) $display("FAIL rd_done_ram_en got %0h exp 0", ram_en); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_byte_write();
        drive(1'b1, 1'b0, 32'h20, 32'h1122_3344, 4'b0010);
        sample();
        checks++; if (ram_we !== 4'b0010) $display("FAIL byte_we got %b exp 0010", ram_we); else passes++;
        checks++; if (mem_valid !== 1'b1) $display("FAIL byte_valid got %0h exp 1", mem_valid); else passes++;
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
        tick();
        sample();
        checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'h0000_3300)
            $display("FAIL byte_readback got v=%0h d=%h exp v=1 d=00003300", mem_valid, mem_read_data); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h30 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            sample();
            checks++; if (mem_valid !== 1'b1 || ram_addr !== 12'(12 + i))
                $display("FAIL b2b_wr%0d got v=%0h a=%h exp v=1 a=%h", i, mem_valid, ram_addr, 12'(12 + i)); else passes++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h30 + 32'(4 * i), 32'h0, 4'h0);
            tick();
            sample();
            checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'hA0 + 32'(i))
                $display("FAIL b2b_rd%0d got v=%0h d=%h exp v=1 d=%h", i, mem_valid, mem_read_data, 32'hA0 + 32'(i)); else passes++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_unmapped();
        drive(1'b1, 1'b0, 32'h3FFC, 32'h55, 4'hF);
        sample();
        checks++; if (ram_en !== 1'b1 || mem_valid !== 1'b1) $display("FAIL ram_top got en=%0h v=%0h exp en=1 v=1", ram_en, mem_valid); else passes++;
        tick();
        drive(1'b1, 1'b1, 32'h4000, 32'h0, 4'h0);
        sample();
        checks++; if (ram_en !== 1'b0 || mem_valid !== 1'b1 || mem_read_data !== 32'h0)
            $display("FAIL ram_limit got en=%0h v=%0h d=%h exp en=0 v=1 d=0", ram_en, mem_valid, mem_read_data); else passes++;
        tick();
        drive(1'b1, 1'b1, 32'h4000_0000, 32'h0, 4'h0);
        sample();
        checks++; if (ram_en !== 1'b0 || mem_valid !== 1'b1 || mem_read_data !== 32'h0)
            $display("FAIL unmapped_rd got en=%0h v=%0h d=%h exp en=0 v=1 d=0", ram_en, mem_valid, mem_read_data); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        checks++; if (acc_req !== 1'b0 || mem_valid !== 1'b1) $display("FAIL unmapped_after got req=%0h v=%0h exp req=0 v=1", acc_req, mem_valid); else passes++;
    endtask

    task automatic test_acc_read();
        tick();
        drive(1'b1, 1'b1, 32'h8000_0004, 32'h0, 4'h0);
        sample();
        checks++; if (mem_valid !== 1'b0 || acc_req !== 1'b0 || ram_en !== 1'b0)
            $display("FAIL acc_issue got v=%0h req=%0h en=%0h exp v=0 req=0 en=0", mem_valid, acc_req, ram_en); else passes++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 2) begin acc_ack = 1'b1; acc_rdata = 32'h1234; end
            sample();
            checks++; if (acc_req !== 1'b1 || mem_valid !== 1'b0 || acc_addr !== 12'h004 || acc_we !== 1'b0)
                $display("FAIL acc_wait%0d got req=%0h v=%0h a=%h we=%0h exp req=1 v=0 a=004 we=0", c, acc_req, mem_valid, acc_addr, acc_we); else passes++;
        end
        tick();
        acc_ack = 1'b0; acc_rdata = 32'hFFFF_FFFF;
        sample();
        checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'h1234 || acc_req !== 1'b0 || ram_en !== 1'b0)
            $display("FAIL acc_resp got v=%0h d=%h req=%0h en=%0h exp v=1 d=00001234 req=0 en=0", mem_valid, mem_read_data, acc_req, ram_en); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'h0) $display("FAIL acc_idle got v=%0h d=%h exp v=1 d=0", mem_valid, mem_read_data); else passes++;
    endtask

    task automatic test_acc_write_fast();
        tick();
        drive(1'b1, 1'b0, 32'h8000_0FFC, 32'h0BAD_F00D, 4'b0101);
        tick();
        acc_ack = 1'b1; acc_rdata = 32'h7777;
        sample();
        checks++; if (acc_req !== 1'b1 || acc_we !== 1'b1 || acc_addr !== 12'hFFC || acc_wdata !== 32'h0BAD_F00D || acc_mask !== 4'b0101)
            $display("FAIL accw_regs got req=%0h we=%0h a=%h d=%h m=%b", acc_req, acc_we, acc_addr, acc_wdata, acc_mask); else passes++;
        tick();
        acc_ack = 1'b0;
        sample();
        checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'h0 || acc_req !== 1'b0)
            $display("FAIL accw_resp got v=%0h d=%h req=%0h exp v=1 d=0 req=0", mem_valid, mem_read_data, acc_req); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h8000_0100, 32'h0, 4'h0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        checks++; if (acc_req !== 1'b1) $display("FAIL rst_mid_pre got req=%0h exp 1", acc_req); else passes++;
        tick();
        reset = 1'b0; acc_ack = 1'b1; acc_rdata = 32'h9999;
        sample();
        checks++; if (acc_req !== 1'b0 || mem_valid !== 1'b1 || mem_read_data !== 32'h0)
            $display("FAIL rst_mid_abort got req=%0h v=%0h d=%h exp req=0 v=1 d=0", acc_req, mem_valid, mem_read_data); else passes++;
        tick();
        acc_ack = 1'b0;
        sample();
        checks++; if (acc_req !== 1'b0 || mem_valid !== 1'b1 || mem_read_data !== 32'h0 || bus_err !== 1'b0)
            $display("FAIL rst_mid_late_ack got req=%0h v=%0h d=%h err=%0h", acc_req, mem_valid, mem_read_data, bus_err); else passes++;
        drive(1'b1, 1'b0, 32'h0, 32'h1, 4'hF);
        sample();
        checks++; if (ram_en !== 1'b1 || mem_valid !== 1'b1) $display("FAIL rst_mid_idle got en=%0h v=%0h exp en=1 v=1", ram_en, mem_valid); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_timeout();
        drive(1'b1, 1'b0, 32'h8000_0010, 32'h42, 4'hF);
`ifdef BUS_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            tick();
            sample();
            checks++; if (acc_req !== 1'b1 || mem_valid !== 1'b0 || bus_err !== 1'b0)
                $display("FAIL tmo_wait%0d got req=%0h v=%0h err=%0h exp req=1 v=0 err=0", c, acc_req, mem_valid, bus_err); else passes++;
        end
        tick();
        sample();
        checks++; if (acc_req !== 1'b0 || mem_valid !== 1'b1 || mem_read_data !== 32'hDEAD_BEEF || bus_err !== 1'b1)
            $display("FAIL tmo_resp got req=%0h v=%0h d=%h err=%0h exp req=0 v=1 d=deadbeef err=1", acc_req, mem_valid, mem_read_data, bus_err); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        sample();
        checks++; if (bus_err !== 1'b0 || mem_valid !== 1'b1) $display("FAIL tmo_after got err=%0h v=%0h exp err=0 v=1", bus_err, mem_valid); else passes++;
`else
        for (int c = 0; c < 10; c++) begin
            tick();
            sample();
            checks++; if (acc_req !== 1'b1 || mem_valid !== 1'b0 || bus_err !== 1'b0)
                $display("FAIL nowait%0d got req=%0h v=%0h err=%0h exp req=1 v=0 err=0", c, acc_req, mem_valid, bus_err); else passes++;
        end
        tick();
        acc_ack = 1'b1;
        tick();
        acc_ack = 1'b0;
        sample();
        checks++; if (mem_valid !== 1'b1 || mem_read_data !== 32'h0 || bus_err !== 1'b0)
            $display("FAIL nowait_resp got v=%0h d=%h err=%0h exp v=1 d=0 err=0", mem_valid, mem_read_data, bus_err); else passes++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
        ram_rdata = 32'h0;
        test_reset();
        test_ram_write_read();
        test_byte_write();
        test_back_to_back();
        test_unmapped();
        test_acc_read();
        test_acc_write_fast();
        test_reset_mid();
        test_timeout();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        checks++;
        $display("FAIL watchdog got time %0t exp finish earlier", $time);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
